sha_wb_frontend: RTL and testbench
==================================

SHA_WB_FRONTEND -- requirements
Module: sha_wb_frontend

Interface
REQ-001 Parameter BASE_ADDRESS, default 32'h30000024: Wishbone base address of the register window.
REQ-002 Parameter MSG_WORDS, default 16, legal range 1..255: number of 32-bit message words per block.
REQ-003 Parameter DIG_WORDS, default 5, legal range 1..15: number of 32-bit digest words.
REQ-004 Parameter CTRL_ID, default 32'h53484131: value returned by the ID register.
REQ-005 wb_clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-006 wb_rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-007 wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone strobe, cycle and write-enable.
REQ-008 wbs_sel_i  in  4, wbs_adr_i  in  32, wbs_dat_i  in  32: byte selects, address, write data.
REQ-009 wbs_ack_o  out  1, wbs_dat_o  out  32: acknowledge, read data.
REQ-010 core_start_o  out  1  one-cycle pulse that starts the hash core.
REQ-011 core_msg_o  out  32*MSG_WORDS  message block; word k on bits [32k+31:32k].
REQ-012 core_done_i  in  1  single-cycle completion pulse from the core; core_digest_i  in  32*DIG_WORDS  digest, valid with core_done_i.
REQ-013 busy_o  out  1  high in RUN; irq_o  out  1  = done & irq_en.

Function
REQ-014 Register map (offset from BASE_ADDRESS): 0x00 NR (RO, 6); 0x04 ID (RO, CTRL_ID); 0x08 CTRL/STATUS; 0x0C MSG_IN (WO); 0x10 DIGEST (RO, sequential); 0x14 IRQ_EN (RW, bit0).
REQ-015 STATUS read format: [0] busy, [1] done, [2] err, [3] irq_en, [15:8] message word index, all other bits 0.
REQ-016 CTRL write: bit1 = 1 performs soft reset (state IDLE, word index 0, digest index 0, done 0); bit2 = 1 clears err (W1C); other bits ignored.
REQ-017 Transaction: wb_active = stb & cyc; wbs_ack_o rises the cycle after wb_active is seen with ack low, stays high exactly one cycle, and never asserts on two consecutive cycles.
REQ-018 Writes with wbs_sel_i != 4'hF are acknowledged and have no effect.
REQ-019 Reads of unmapped offsets or of MSG_IN return 32'h0FFFFFEA; writes to read-only or unmapped offsets are acknowledged and ignored.
REQ-020 States: IDLE, LOAD, RUN, DONE.
REQ-021 MSG_IN write in IDLE, LOAD or DONE stores the word at the current index and increments the index; a write in IDLE or DONE also clears done and digest index and enters LOAD.
REQ-022 The MSG_WORDS-th write resets the index to 0, enters RUN and pulses core_start_o in the following cycle.
REQ-023 MSG_IN write in RUN is acknowledged, discarded, and sets err (sticky).
REQ-024 In RUN, core_done_i captures core_digest_i into an internal register, sets done and enters DONE; core_done_i in any other state is ignored.
REQ-025 DIGEST read in DONE returns digest word[idx] and advances idx, wrapping from DIG_WORDS-1 to 0; in other states it returns 32'hF00DF00D with idx unchanged.
REQ-026 Simultaneous soft reset and core_done_i: soft reset wins and no digest is captured.
REQ-027 core_msg_o holds the last stored words and only changes on MSG_IN writes.

Reset
REQ-028 While wb_rst_ni is low: state IDLE, index 0, digest index 0, message and digest registers 0, done/err/irq_en 0, wbs_ack_o 0, wbs_dat_o 0, core_start_o 0, busy_o 0, irq_o 0.
REQ-029 Reset asserted mid-transaction or in RUN aborts immediately; no ack or core_start_o is issued for the aborted operation.

Verification
REQ-030 Read 0x00 and 0x04 -> 32'h6 and 32'h53484131, each ack exactly one cycle with stb held for three cycles.
REQ-031 16 MSG_IN writes 32'h0..32'hF -> core_msg_o[31:0]=0, core_msg_o[511:480]=32'hF, one core_start_o pulse, STATUS = 32'h1.
REQ-032 With IRQ_EN=1, core_done_i and digest words 1..5 -> irq_o=1, STATUS bit1=1, six DIGEST reads return 1,2,3,4,5,1.
REQ-033 MSG_IN write during RUN -> STATUS bit2=1; CTRL write 32'h4 -> bit2=0, state unchanged.
REQ-034 DIGEST read in IDLE -> 32'hF00DF00D; write with wbs_sel_i=4'h3 to MSG_IN -> index unchanged.
REQ-035 wb_rst_ni low for one cycle in RUN -> all outputs 0 and STATUS = 32'h0 after release.

Source files
------------

// File: rtl/sha_wb_frontend.sv
// Wishbone register front end for a block hash core: message loading, start pulse,
// digest capture and sequential digest readout.
module sha_wb_frontend #(
    parameter logic [31:0] BASE_ADDRESS = 32'h30000024,
    parameter int unsigned MSG_WORDS    = 16,
    parameter int unsigned DIG_WORDS    = 5,
    parameter logic [31:0] CTRL_ID      = 32'h53484131
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_ni,
    input  logic                      wbs_stb_i,
    input  logic                      wbs_cyc_i,
    input  logic                      wbs_we_i,
    input  logic [3:0]                wbs_sel_i,
    input  logic [31:0]               wbs_adr_i,
    input  logic [31:0]               wbs_dat_i,
    output logic                      wbs_ack_o,
    output logic [31:0]               wbs_dat_o,
    output logic                      core_start_o,
    output logic [32*MSG_WORDS-1:0]   core_msg_o,
    input  logic                      core_done_i,
    input  logic [32*DIG_WORDS-1:0]   core_digest_i,
    output logic                      busy_o,
    output logic                      irq_o
);

    localparam logic [31:0] OffNr     = 32'h00;
    localparam logic [31:0] OffId     = 32'h04;
    localparam logic [31:0] OffCtrl   = 32'h08;
    localparam logic [31:0] OffMsg    = 32'h0C;
    localparam logic [31:0] OffDigest = 32'h10;
    localparam logic [31:0] OffIrqEn  = 32'h14;

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_t;

    state_t                      state;
    logic [7:0]                  msg_idx;
    logic [3:0]                  dig_idx;
    logic                        done;
    logic                        err;
    logic                        irq_en;
    logic [MSG_WORDS-1:0][31:0]  msg;
    logic [DIG_WORDS-1:0][31:0]  digest;

    logic        accept;
    logic        rd_en;
    logic        wr_ok;
    logic        soft_rst;
    logic        last_word;
    logic [31:0] off;
    logic [31:0] status;
    logic [31:0] dig_word;
    logic [31:0] rd_data;

    // A transaction is taken only when ack is low, so ack can never stay high two cycles.
    assign accept    = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
    assign rd_en     = accept & ~wbs_we_i;
    assign wr_ok     = accept & wbs_we_i & (wbs_sel_i == 4'hF);
    assign off       = wbs_adr_i - BASE_ADDRESS;
    assign soft_rst  = wr_ok && (off == OffCtrl) && wbs_dat_i[1];
    assign last_word = (msg_idx == 8'(MSG_WORDS - 1));
    assign status    = {16'h0, msg_idx, 4'h0, irq_en, err, done, state == StRun};

    assign core_msg_o = msg;
    assign busy_o     = (state == StRun);
    assign irq_o      = done & irq_en;

    always_comb begin
        dig_word = 32'h0;
        for (int unsigned k = 0; k < DIG_WORDS; k++) begin
            if (dig_idx == 4'(k)) dig_word = digest[k];
        end
    end

    always_comb begin
        rd_data = 32'h0FFFFFEA;
        case (off)
            OffNr:     rd_data = 32'h6;
            OffId:     rd_data = CTRL_ID;
            OffCtrl:   rd_data = status;
            OffDigest: rd_data = (state == StDone) ? dig_word : 32'hF00DF00D;
            OffIrqEn:  rd_data = {31'h0, irq_en};
            default:   rd_data = 32'h0FFFFFEA;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state        <= StIdle;
            msg_idx      <= 8'h0;
            dig_idx      <= 4'h0;
            done         <= 1'b0;
            err          <= 1'b0;
            irq_en       <= 1'b0;
            msg          <= '0;
            digest       <= '0;
            wbs_ack_o    <= 1'b0;
            wbs_dat_o    <= 32'h0;
            core_start_o <= 1'b0;
        end else begin
            wbs_ack_o    <= accept;
            core_start_o <= 1'b0;

            if (rd_en) begin
                wbs_dat_o <= rd_data;
                if (off == OffDigest && state == StDone) begin
                    dig_idx <= (dig_idx == 4'(DIG_WORDS - 1)) ? 4'h0 : dig_idx + 4'h1;
                end
            end

            if (wr_ok) begin
                case (off)
                    OffCtrl: begin
                        if (wbs_dat_i[2]) err <= 1'b0;
                    end
                    OffMsg: begin
                        if (state == StRun) begin
                            err <= 1'b1;
                        end else begin
                            for (int unsigned k = 0; k < MSG_WORDS; k++) begin
                                if (msg_idx == 8'(k)) msg[k] <= wbs_dat_i;
                            end
                            // First word of a new block forgets the previous result.
                            if (state != StLoad) begin
                                done    <= 1'b0;
                                dig_idx <= 4'h0;
                            end
                            if (last_word) begin
                                msg_idx      <= 8'h0;
                                state        <= StRun;
                                core_start_o <= 1'b1;
                            end else begin
                                msg_idx <= msg_idx + 8'h1;
                                state   <= StLoad;
                            end
                        end
                    end
                    OffIrqEn: irq_en <= wbs_dat_i[0];
                    default: ;
                endcase
            end

            if (state == StRun && core_done_i && !soft_rst) begin
                digest <= core_digest_i;
                done   <= 1'b1;
                state  <= StDone;
            end

            // Soft reset is applied last so it overrides everything above.
            if (soft_rst) begin
                state   <= StIdle;
                msg_idx <= 8'h0;
                dig_idx <= 4'h0;
                done    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sha_wb_frontend.sv
// Self-checking bench for sha_wb_frontend: vector table, directed corner cases and
// randomized traffic against a register-level reference model.
module tb_sha_wb_frontend;

    localparam int MW = 16;
    localparam int DW = 5;
    localparam logic [31:0] BASE = 32'h30000024;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]      sel = 4'h0;
    logic [31:0]     adr = 32'h0, wdat = 32'h0;
    logic            ack;
    logic [31:0]     rdat;
    logic            start;
    logic [32*MW-1:0] msg_bus;
    logic            core_done = 1'b0;
    logic [32*DW-1:0] digest_bus = '0;
    logic            busy, irq;

    sha_wb_frontend #(
        .BASE_ADDRESS(BASE),
        .MSG_WORDS(MW),
        .DIG_WORDS(DW),
        .CTRL_ID(32'h53484131)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_ni(rst_n),
        .wbs_stb_i(stb),
        .wbs_cyc_i(cyc),
        .wbs_we_i(we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(wdat),
        .wbs_ack_o(ack),
        .wbs_dat_o(rdat),
        .core_start_o(start),
        .core_msg_o(msg_bus),
        .core_done_i(core_done),
        .core_digest_i(digest_bus),
        .busy_o(busy),
        .irq_o(irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int start_seen = 0;

    always @(posedge clk) if (start === 1'b1) start_seen++;

    // Reference model: register contents and flags only.
    logic [31:0] m_msg[MW];
    logic [31:0] m_dig[DW];
    int m_idx, m_didx, m_starts;
    bit m_busy, m_done, m_err, m_irq;

    task automatic model_reset();
        for (int k = 0; k < MW; k++) m_msg[k] = 32'h0;
        for (int k = 0; k < DW; k++) m_dig[k] = 32'h0;
        m_idx = 0; m_didx = 0;
        m_busy = 0; m_done = 0; m_err = 0; m_irq = 0;
    endtask

    task automatic model_write(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
        if (s != 4'hF) return;
        if (o == 32'h08) begin
            if (d[2]) m_err = 0;
            if (d[1]) begin m_busy = 0; m_done = 0; m_idx = 0; m_didx = 0; end
        end else if (o == 32'h0C) begin
            if (m_busy) m_err = 1;
            else begin
                m_msg[m_idx] = d;
                if (m_done) begin m_done = 0; m_didx = 0; end
                m_idx++;
                if (m_idx == MW) begin m_idx = 0; m_busy = 1; m_starts++; end
            end
        end else if (o == 32'h14) begin
            m_irq = d[0];
        end
    endtask

    task automatic model_read(input logic [31:0] o, output logic [31:0] r);
        case (o)
            32'h00: r = 32'h6;
            32'h04: r = 32'h53484131;
            32'h08: r = {16'h0, 8'(m_idx), 4'h0, m_irq, m_err, m_done, m_busy};
            32'h10: begin
                if (m_done && !m_busy) begin
                    r = m_dig[m_didx];
                    m_didx = (m_didx + 1) % DW;
                end else r = 32'hF00DF00D;
            end
            32'h14: r = {31'h0, m_irq};
            default: r = 32'h0FFFFFEA;
        endcase
    endtask

    task automatic model_core_done(input logic [32*DW-1:0] d);
        if (m_busy) begin
            for (int k = 0; k < DW; k++) m_dig[k] = d[k*32 +: 32];
            m_done = 1; m_busy = 0;
        end
    endtask

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One Wishbone transaction, bounded wait for ack; optional core_done on the accept edge.
    task automatic wb_cycle(input logic [31:0] o, input logic w, input logic [3:0] s,
                            input logic [31:0] d, input bit with_done, output logic [31:0] r);
        bit got = 0;
        r = 32'h0;
        adr = BASE + o; we = w; sel = s; wdat = d; stb = 1'b1; cyc = 1'b1;
        if (with_done) core_done = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            core_done = 1'b0;
            if (ack === 1'b1) begin got = 1; r = rdat; end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        total++;
        if (!got) begin
            bad++;
            $display("FAIL ack_timeout: got no ack expected ack for offset %0h", o);
        end
    endtask

    task automatic wb_wr(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        wb_cycle(o, 1'b1, s, d, 1'b0, r);
        model_write(o, d, s);
    endtask

    task automatic wb_rd(input string name, input logic [31:0] o);
        logic [31:0] r, e;
        wb_cycle(o, 1'b0, 4'hF, 32'h0, 1'b0, r);
        model_read(o, e);
        check(name, r, e);
    endtask

    task automatic wb_rd_const(input string name, input logic [31:0] o, input logic [31:0] e);
        logic [31:0] r, dummy;
        wb_cycle(o, 1'b0, 4'hF, 32'h0, 1'b0, r);
        model_read(o, dummy);
        check(name, r, e);
    endtask

    task automatic pulse_done(input logic [32*DW-1:0] d);
        digest_bus = d; core_done = 1'b1;
        @(posedge clk); #1;
        core_done = 1'b0;
        digest_bus = {DW{$urandom()}};
        model_core_done(d);
    endtask

    task automatic check_outputs(input string tag);
        logic [511:0] em;
        em = '0;
        for (int k = 0; k < MW; k++) em[k*32 +: 32] = m_msg[k];
        @(posedge clk); #1;
        check({tag, "_msg"}, msg_bus, em);
        check({tag, "_busy"}, busy, m_busy);
        check({tag, "_irq"}, irq, m_done & m_irq);
        check({tag, "_starts"}, start_seen, m_starts);
        check({tag, "_start_idle"}, start, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"}, ack, 1'b0);
        check({tag, "_dat"}, rdat, 32'h0);
        check({tag, "_start"}, start, 1'b0);
        check({tag, "_msg"}, msg_bus, '0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_irq"}, irq, 1'b0);
    endtask

    typedef struct {
        logic [31:0] off;
        logic        wr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];

    initial begin
        logic [31:0] r;
        logic [32*DW-1:0] dg;
        int base_starts;

        vecs[0]  = '{32'h00, 1'b0, 4'hF, 32'h0, 32'h6};
        vecs[1]  = '{32'h04, 1'b0, 4'hF, 32'h0, 32'h53484131};
        vecs[2]  = '{32'h08, 1'b0, 4'hF, 32'h0, 32'h0};
        vecs[3]  = '{32'h0C, 1'b0, 4'hF, 32'h0, 32'h0FFFFFEA};
        vecs[4]  = '{32'h10, 1'b0, 4'hF, 32'h0, 32'hF00DF00D};
        vecs[5]  = '{32'h18, 1'b0, 4'hF, 32'h0, 32'h0FFFFFEA};
        vecs[6]  = '{32'hFFFFFFFC, 1'b0, 4'hF, 32'h0, 32'h0FFFFFEA};
        vecs[7]  = '{32'h14, 1'b1, 4'hF, 32'h1, 32'h0};
        vecs[8]  = '{32'h14, 1'b0, 4'hF, 32'h0, 32'h1};
        vecs[9]  = '{32'h08, 1'b0, 4'hF, 32'h0, 32'h8};
        vecs[10] = '{32'h14, 1'b1, 4'h3, 32'h0, 32'h0};
        vecs[11] = '{32'h14, 1'b0, 4'hF, 32'h0, 32'h1};
        vecs[12] = '{32'h00, 1'b1, 4'hF, 32'hFFFFFFFF, 32'h0};
        vecs[13] = '{32'h00, 1'b0, 4'hF, 32'h0, 32'h6};
        vecs[14] = '{32'h14, 1'b1, 4'hF, 32'h0, 32'h0};
        vecs[15] = '{32'h08, 1'b0, 4'hF, 32'h0, 32'h0};

        model_reset();
        m_starts = 0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Ack pattern with strobe held over three edges.
        for (int t = 0; t < 2; t++) begin
            adr = BASE + (t == 0 ? 32'h0 : 32'h4); we = 1'b0; sel = 4'hF;
            stb = 1'b1; cyc = 1'b1;
            @(posedge clk); #1;
            check("held_ack1", ack, 1'b1);
            check("held_dat", rdat, t == 0 ? 32'h6 : 32'h53484131);
            @(posedge clk); #1;
            check("held_ack_gap", ack, 1'b0);
            @(posedge clk); #1;
            check("held_ack2", ack, 1'b1);
            stb = 1'b0; cyc = 1'b0;
            @(posedge clk); #1;
            check("held_ack_drop", ack, 1'b0);
        end

        // Register map vectors.
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].wr) wb_wr(vecs[i].off, vecs[i].wdata, vecs[i].sel);
            else wb_rd_const($sformatf("vec%0d", i), vecs[i].off, vecs[i].exp);
        end

        // Full block of words 0..15.
        base_starts = start_seen;
        for (int i = 0; i < MW; i++) wb_wr(32'h0C, 32'(i), 4'hF);
        check("blk_word0", msg_bus[31:0], 32'h0);
        check("blk_word15", msg_bus[511:480], 32'hF);
        wb_rd_const("blk_status", 32'h08, 32'h1);
        check("blk_one_start", start_seen - base_starts, 1);
        check_outputs("blk");

        // Write during RUN sets err; W1C clears it without leaving RUN.
        wb_wr(32'h0C, 32'hDEADBEEF, 4'hF);
        wb_rd_const("run_err", 32'h08, 32'h5);
        wb_wr(32'h08, 32'h4, 4'hF);
        wb_rd_const("err_clr", 32'h08, 32'h1);
        check_outputs("run");

        // Completion with interrupt enabled and digest readout wrap.
        wb_wr(32'h14, 32'h1, 4'hF);
        for (int k = 0; k < DW; k++) dg[k*32 +: 32] = 32'(k + 1);
        pulse_done(dg);
        check("irq_set", irq, 1'b1);
        wb_rd_const("done_status", 32'h08, 32'hA);
        for (int k = 0; k < 6; k++) wb_rd_const($sformatf("dig%0d", k), 32'h10, 32'((k % DW) + 1));
        pulse_done({DW{32'hAAAA5555}});
        wb_rd_const("done_ignored", 32'h10, 32'h2);

        // Soft reset, then idle digest read and partial-select write.
        wb_wr(32'h08, 32'h2, 4'hF);
        wb_rd_const("idle_digest", 32'h10, 32'hF00DF00D);
        wb_wr(32'h0C, 32'h12345678, 4'h3);
        wb_rd_const("sel3_idx", 32'h08, 32'h8);
        for (int i = 0; i < 3; i++) wb_wr(32'h0C, $urandom(), 4'hF);
        wb_rd_const("load3_idx", 32'h08, 32'h0308);
        wb_wr(32'h0C, 32'h12345678, 4'h3);
        wb_rd_const("sel3_idx2", 32'h08, 32'h0308);
        check_outputs("partial");

        // Soft reset coinciding with core_done: reset wins.
        for (int i = 3; i < MW; i++) wb_wr(32'h0C, $urandom(), 4'hF);
        digest_bus = {DW{32'h77777777}};
        wb_cycle(32'h08, 1'b1, 4'hF, 32'h2, 1'b1, r);
        model_write(32'h08, 32'h2, 4'hF);
        wb_rd_const("sr_vs_done", 32'h08, 32'h8);
        wb_rd_const("sr_vs_done_dig", 32'h10, 32'hF00DF00D);
        check_outputs("sr_done");

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            int c;
            c = $urandom_range(0, 99);
            if (c < 45) begin
                wb_wr(32'h0C, $urandom(), ($urandom_range(0, 7) == 0) ? 4'($urandom()) : 4'hF);
            end else if (c < 60) begin
                wb_rd("rnd_digest", 32'h10);
            end else if (c < 70) begin
                wb_rd("rnd_status", 32'h08);
            end else if (c < 75) begin
                wb_wr(32'h08, ($urandom() & ~32'h2) | (($urandom_range(0, 9) == 0) ? 32'h2 : 32'h0),
                      4'hF);
            end else if (c < 80) begin
                wb_wr(32'h14, $urandom(), 4'hF);
            end else if (c < 95) begin
                for (int k = 0; k < DW; k++) dg[k*32 +: 32] = $urandom();
                pulse_done(dg);
            end else begin
                wb_rd("rnd_any", 32'($urandom_range(0, 7)) << 2);
            end
            check_outputs("rnd");
        end

        // Reset during the final message write: no ack, no start.
        wb_wr(32'h08, 32'h2, 4'hF);
        for (int i = 0; i < MW - 1; i++) wb_wr(32'h0C, $urandom(), 4'hF);
        adr = BASE + 32'h0C; we = 1'b1; sel = 4'hF; wdat = 32'hCAFEF00D;
        stb = 1'b1; cyc = 1'b1; rst_n = 1'b0;
        @(posedge clk); #1;
        check_all_zero("rst_mid");
        stb = 1'b0; cyc = 1'b0; we = 1'b0; rst_n = 1'b1;
        model_reset();
        check_outputs("rst_mid_after");

        // Reset pulse while RUN.
        for (int i = 0; i < MW; i++) wb_wr(32'h0C, $urandom(), 4'hF);
        check_outputs("pre_rst_run");
        check("run_busy", busy, 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        check_all_zero("rst_run");
        wb_rd_const("rst_run_status", 32'h08, 32'h0);
        check_outputs("rst_run_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
